// File: rtl/oai22_tt_checker.sv
// Exhaustive truth-table checker for a 4-input, single-output OAI22-style cell.
// Walks all 16 {A1,A2,B1,B2} vectors, waits a settle window per vector,
// samples ZN, and accumulates a mismatch count plus the first failing vector.
module oai22_tt_checker #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] EXP_TABLE     = 16'h111F,
    parameter int          CNT_W         = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dut_zn,
    output logic [3:0]       vec_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_fail_valid,
    output logic [3:0]       first_fail_vec
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    // Last value of the settle counter before moving on to SAMPLE.
    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       settle_cnt_q, settle_cnt_d;
    logic [3:0]       vec_out_q, vec_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             ffv_q, ffv_d;
    logic [3:0]       ffvec_q, ffvec_d;

    logic             mismatch;
    logic [CNT_W-1:0] err_next;

    // State and result registers; reset aborts any sweep and clears all results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= 4'd0;
            settle_cnt_q <= 4'd0;
            vec_out_q    <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            ffv_q        <= 1'b0;
            ffvec_q      <= 4'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            settle_cnt_q <= settle_cnt_d;
            vec_out_q    <= vec_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_cnt_q    <= err_cnt_d;
            ffv_q        <= ffv_d;
            ffvec_q      <= ffvec_d;
        end
    end

    // Next-state and result update for the sweep sequencer.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        settle_cnt_d = settle_cnt_q;
        vec_out_d    = vec_out_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_cnt_d    = err_cnt_q;
        ffv_d        = ffv_q;
        ffvec_d      = ffvec_q;
        mismatch     = 1'b0;
        err_next     = err_cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    idx_d     = 4'd0;
                    err_cnt_d = '0;
                    ffv_d     = 1'b0;
                    ffvec_d   = 4'd0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_DRIVE;
                end
            end

            S_DRIVE: begin
                vec_out_d    = idx_q;
                settle_cnt_d = 4'd0;
                state_d      = (SETTLE_CYCLES > 0) ? S_SETTLE : S_SAMPLE;
            end

            S_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 4'd1;
                end
            end

            S_SAMPLE: begin
                // Case-inequality so that an X or Z response counts as a failure.
                mismatch = (dut_zn !== EXP_TABLE[idx_q]);
                if (mismatch) begin
                    if (err_cnt_q != CNT_MAX) begin
                        err_next = err_cnt_q + CNT_ONE;
                    end
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = idx_q;
                    end
                end
                err_cnt_d = err_next;
                if (idx_q == 4'hF) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_next == '0);
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_DRIVE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign vec_out          = vec_out_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_cnt          = err_cnt_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_oai22_tt_checker.sv
// Self-checking bench for oai22_tt_checker: a default-parameter instance and a
// SETTLE_CYCLES=0 / CNT_W=2 instance, each fed from a response table indexed by vec_out.
module tb_oai22_tt_checker;

    localparam int P_A = 4;   // cycles per vector, default instance (settle 2 + 2)
    localparam int P_B = 2;   // cycles per vector, settle-0 instance

    logic        clk;
    logic        rst_n;
    logic        start_a, start_b;
    logic [15:0] zn_tab_a, zn_tab_b;
    logic        dut_zn_a, dut_zn_b;

    logic [3:0]  vec_a, ffvec_a;
    logic        busy_a, done_a, pass_a, ffv_a;
    logic [4:0]  err_a;

    logic [3:0]  vec_b, ffvec_b;
    logic        busy_b, done_b, pass_b, ffv_b;
    logic [1:0]  err_b;

    int total = 0;
    int bad   = 0;

    assign dut_zn_a = zn_tab_a[vec_a];
    assign dut_zn_b = zn_tab_b[vec_b];

    oai22_tt_checker u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .dut_zn(dut_zn_a),
        .vec_out(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_cnt(err_a), .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a)
    );

    oai22_tt_checker #(.SETTLE_CYCLES(0), .EXP_TABLE(16'h111F), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .dut_zn(dut_zn_b),
        .vec_out(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_b), .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural OAI22: ZN = not((A1 or A2) and (B1 or B2)).
    function automatic logic oai_ref(input logic [3:0] v);
        logic a_any, b_any;
        a_any = v[3] | v[2];
        b_any = v[1] | v[0];
        return !(a_any && b_any);
    endfunction

    function automatic logic [15:0] oai_table();
        logic [15:0] t;
        for (int i = 0; i < 16; i++) t[i] = oai_ref(4'(i));
        return t;
    endfunction

    // Expected sweep results for a response table, counted vector by vector.
    task automatic model(input logic [15:0] tab, input int sat,
                         output int e_err, output int e_first, output logic e_ffv);
        e_err = 0; e_first = 0; e_ffv = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (tab[i] != oai_ref(4'(i))) begin
                if (!e_ffv) begin
                    e_ffv = 1'b1;
                    e_first = i;
                end
                e_err++;
            end
        end
        if (e_err > sat) e_err = sat;
    endtask

    // Full sweep on the default instance with per-cycle vec_out/busy/done checks.
    // restart_at: cycle offset at which start is re-pulsed (must be ignored), -1 for none.
    task automatic run_sweep(input string name, input logic [15:0] tab, input int restart_at);
        int e_err, e_first;
        logic e_ffv;
        model(tab, 31, e_err, e_first, e_ffv);
        zn_tab_a = tab;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        total++;
        if (busy_a !== 1'b1 || done_a !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s start_accept: busy=%b done=%b want busy=1 done=0", name, busy_a, done_a);
        end
        for (int j = 1; j <= 16 * P_A; j++) begin
            @(negedge clk);
            total++;
            if (vec_a !== 4'((j - 1) / P_A)) begin
                bad++;
                $display("[TB] FAIL %s vec_step j=%0d: got %0d want %0d", name, j, vec_a, (j - 1) / P_A);
            end
            total++;
            if (done_a !== (j == 16 * P_A) || busy_a !== (j != 16 * P_A)) begin
                bad++;
                $display("[TB] FAIL %s done_timing j=%0d: done=%b busy=%b", name, j, done_a, busy_a);
            end
            start_a = (j == restart_at);
        end
        start_a = 1'b0;
        total++;
        if (err_a !== 5'(e_err) || ffv_a !== e_ffv || (e_ffv && ffvec_a !== 4'(e_first))) begin
            bad++;
            $display("[TB] FAIL %s result: err=%0d ffv=%b ffvec=%0d want err=%0d ffv=%b ffvec=%0d",
                     name, err_a, ffv_a, ffvec_a, e_err, e_ffv, e_first);
        end
        total++;
        if (pass_a !== (e_err == 0)) begin
            bad++;
            $display("[TB] FAIL %s pass: got %b want %b", name, pass_a, e_err == 0);
        end
        repeat (3) @(negedge clk);
        total++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || pass_a !== (e_err == 0) || vec_a !== 4'hF) begin
            bad++;
            $display("[TB] FAIL %s hold: done=%b busy=%b pass=%b vec=%0d", name, done_a, busy_a, pass_a, vec_a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        zn_tab_a = 16'h0; zn_tab_b = 16'h0;
        #3;
        total++;
        if ({vec_a, busy_a, done_a, pass_a, err_a, ffv_a, ffvec_a} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_a: vec=%0d busy=%b done=%b pass=%b err=%0d ffv=%b", vec_a, busy_a, done_a, pass_a, err_a, ffv_a);
        end
        total++;
        if ({vec_b, busy_b, done_b, pass_b, err_b, ffv_b, ffvec_b} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_b: vec=%0d busy=%b done=%b", vec_b, busy_b, done_b);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_model_pass();
        repeat (8) @(negedge clk);
        run_sweep("oai_model", oai_table(), -1);
    endtask

    task automatic test_stuck();
        run_sweep("tied0", 16'h0000, -1);
        run_sweep("tied1", 16'hFFFF, -1);
    endtask

    task automatic test_ignore_start();
        run_sweep("restart_v6", oai_table(), 1 + 6 * P_A + 1);
        run_sweep("rerun", oai_table(), -1);
        run_sweep("late_start_v15", 16'h0000, 16 * P_A - 1);
    endtask

    task automatic test_async_reset();
        zn_tab_a = 16'h0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        for (int j = 1; j <= 1 + 9 * P_A + 1; j++) @(negedge clk);
        total++;
        if (vec_a !== 4'd9 || busy_a !== 1'b1) begin
            bad++;
            $display("[TB] FAIL pre_reset: vec=%0d busy=%b want 9/1", vec_a, busy_a);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({vec_a, busy_a, done_a, pass_a, err_a, ffv_a, ffvec_a} !== '0) begin
            bad++;
            $display("[TB] FAIL async_reset: vec=%0d busy=%b err=%0d ffv=%b", vec_a, busy_a, err_a, ffv_a);
        end
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || vec_a !== 4'd0) begin
            bad++;
            $display("[TB] FAIL post_reset_idle: busy=%b done=%b vec=%0d", busy_a, done_a, vec_a);
        end
        run_sweep("after_reset", 16'h0000, -1);
    endtask

    task automatic test_settle0_saturate();
        int e_err, e_first;
        logic e_ffv;
        model(16'hFFFF, 3, e_err, e_first, e_ffv);
        zn_tab_b = 16'hFFFF;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        for (int j = 1; j <= 16 * P_B; j++) begin
            @(negedge clk);
            total++;
            if (done_b !== (j == 16 * P_B) || vec_b !== 4'((j - 1) / P_B)) begin
                bad++;
                $display("[TB] FAIL settle0_timing j=%0d: done=%b vec=%0d want vec=%0d", j, done_b, vec_b, (j - 1) / P_B);
            end
        end
        total++;
        if (err_b !== 2'(e_err) || ffvec_b !== 4'(e_first) || ffv_b !== e_ffv || pass_b !== 1'b0) begin
            bad++;
            $display("[TB] FAIL settle0_result: err=%0d ffvec=%0d ffv=%b pass=%b want err=%0d ffvec=%0d",
                     err_b, ffvec_b, ffv_b, pass_b, e_err, e_first);
        end
    endtask

    task automatic test_random();
        logic [15:0] flips;
        for (int n = 0; n < 4; n++) begin
            flips = 16'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_sweep("random", oai_table() ^ flips, -1);
        end
    endtask

    initial begin
        test_reset();
        test_model_pass();
        test_stuck();
        test_ignore_start();
        test_async_reset();
        test_settle0_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oai22_tt_checker.md
Name: oai22_tt_checker

Overview:
- Synthesizable, self-checking response end for the OAI22_X1 exhaustive truth-table stimulus.
- Drives all 16 input vectors {A1,A2,B1,B2} into a 4-input single-output cell, waits a settle window, and samples ZN.
- Compares ZN against a parameterized expected truth table and reports pass/fail, the mismatch count and the first failing vector.
- Sits between the cell-level DUT and the regression harness, replacing manual inspection of printed tables.

Parameters:
- SETTLE_CYCLES, 2: clock cycles between driving a vector and sampling ZN; legal range 0..15.
- EXP_TABLE, 16'h111F: expected ZN per vector; bit i is the response to vector i. The default is OAI22: ZN = ~((A1|A2)&(B1|B2)).
- CNT_W, 5: width of the mismatch counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to run a full sweep.
- dut_zn  input  1  DUT output ZN.
- vec_out  output  4  stimulus vector; bit3=A1, bit2=A2, bit1=B1, bit0=B2.
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; held until the next accepted start.
- pass  output  1  valid while done=1; high when err_cnt==0.
- err_cnt  output  CNT_W  number of mismatching vectors; saturates at all-ones.
- first_fail_valid  output  1  at least one mismatch has been recorded.
- first_fail_vec  output  4  index of the first mismatching vector.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE.
  - All outputs go to 0: vec_out=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_valid=0, first_fail_vec=0.
  - A reset mid-sweep aborts the sweep immediately. No partial result is retained.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE or DONE with start=1 at a clock edge:
  - Vector index idx<=0.
  - err_cnt, first_fail_valid and first_fail_vec are cleared; done<=0, pass<=0, busy<=1.
  - Next state is DRIVE.
- start is ignored in DRIVE, SETTLE and SAMPLE.
- DRIVE (1 cycle): vec_out<=idx, settle counter<=0.
  - Next state is SETTLE if SETTLE_CYCLES>0, otherwise SAMPLE.
- SETTLE (SETTLE_CYCLES cycles): counter increments each cycle. When it reaches SETTLE_CYCLES-1, next state is SAMPLE.
- SAMPLE (1 cycle): mismatch = (dut_zn !== EXP_TABLE[idx]).
  - X or Z on dut_zn counts as a mismatch in simulation.
  - On mismatch:
    - err_cnt increments, saturating at 2^CNT_W-1.
    - If first_fail_valid=0: first_fail_vec<=idx and first_fail_valid<=1.
  - If idx==15: next state is DONE, busy<=0, done<=1, pass<=(final err_cnt==0). pass must include a mismatch on vector 15 itself.
  - Otherwise: idx<=idx+1 and next state is DRIVE.
- vec_out holds its value from DRIVE through SAMPLE. After the sweep it holds 4'hF until the next start or reset.
- Latency: with start accepted at edge k, done rises at edge k+16*(SETTLE_CYCLES+2).
  - Default parameters: 64 cycles.
  - SETTLE_CYCLES=0: 32 cycles.
- Per vector, ZN is sampled SETTLE_CYCLES+1 edges after vec_out changes.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- done and pass stay stable in DONE indefinitely.
- start asserted in the same cycle that SAMPLE of vector 15 completes is ignored.

Test Plan:
- Default parameters, dut_zn driven by a behavioural OAI22 model of vec_out, pulse start at cycle 10 -> busy=1 from cycle 11.
  - vec_out steps 0..15 every 4 cycles.
  - done=1 at edge 74, pass=1, err_cnt=0, first_fail_valid=0.
- dut_zn tied to 0 -> done=1, pass=0, err_cnt=7 (vectors 0,1,2,3,4,8,12), first_fail_vec=0, first_fail_valid=1.
- dut_zn tied to 1 -> err_cnt=9 (vectors 5,6,7,9,10,11,13,14,15), first_fail_vec=5, pass=0.
- Correct model, start re-pulsed while busy at vector 6 -> ignored; the sweep finishes at the original cycle with pass=1.
  - A second start after done clears err_cnt and done, then reruns with pass=1.
- Stuck-at-0 model, rst_n pulsed low asynchronously between edges during vector 9 -> all outputs 0 immediately, state IDLE.
  - A following start completes a clean sweep with err_cnt=7.
- SETTLE_CYCLES=0, CNT_W=2, dut_zn tied to 1 -> done 32 cycles after start, err_cnt saturates at 3, first_fail_vec=5.
